up_param_core: RTL and testbench

//  Parametrised successor of the 4-bit accumulator microprocessor: two-phase fetch/execute core, DATA_W-wide datapath.

---
 rtl/up_param_pkg.sv | 58 +++++
 rtl/up_param_core_if.sv | 42 ++++
 rtl/up_param_alu.sv | 40 ++++
 rtl/up_param_core.sv | 174 +++++++++++++++++
 tb/tb_up_param_core.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/up_param_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, phase
// encoding, ALU operation select and opcode classification helpers.
package up_param_pkg;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    typedef enum logic {
        PhFetch = 1'b0,
        PhExec  = 1'b1
    } phase_e;

    typedef enum logic [1:0] {
        AluPass,
        AluAdd,
        AluCmp,
        AluNand
    } alu_op_e;

    // Opcodes whose second word (RAM address low part / jump target) follows in ROM
    function automatic logic is_two_word(input logic [3:0] op);
        case (op)
            OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST,
            OP_JZ, OP_JNZ, OP_ADDM, OP_JMP, OP_NANDM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        case (op)
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Opcodes that touch data RAM (read or write)
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/up_param_core_if.sv
// Memory-side bus of up_param_core: program ROM port and data RAM port.
// With UP_RAM_WAIT_EN defined the bus carries a ram_ready wait-state input.
interface up_param_core_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PW_W   = DATA_W + 4,
    parameter int unsigned ADDR_W = DATA_W + PW_W
);
    logic [PW_W-1:0]   program_byte;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] address_RAM;
    logic [DATA_W-1:0] data_bus;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
`ifdef UP_RAM_WAIT_EN
    logic              ram_ready;
`endif

    modport master (
        input  program_byte,
        input  ram_rdata,
`ifdef UP_RAM_WAIT_EN
        input  ram_ready,
`endif
        output PC,
        output address_RAM,
        output data_bus,
        output ram_we
    );

    modport slave (
        output program_byte,
        output ram_rdata,
`ifdef UP_RAM_WAIT_EN
        output ram_ready,
`endif
        input  PC,
        input  address_RAM,
        input  data_bus,
        input  ram_we
    );

endinterface

// File: rtl/up_param_alu.sv
// Combinational ALU: pass-through, add, compare (a - b via a + ~b + 1) and NAND.
// Carry comes from the DATA_W+1 bit sum; zero reflects the result.
module up_param_alu
    import up_param_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] sum;

    // Operation select; carry only meaningful for add/compare
    always_comb begin
        sum      = '0;
        result_o = b_i;
        carry_o  = 1'b0;
        unique case (op_i)
            AluPass: result_o = b_i;
            AluAdd: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            AluCmp: begin
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            AluNand: result_o = ~(a_i & b_i);
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/up_param_core.sv
// Two-phase (fetch/exec) accumulator core with a DATA_W-wide datapath.
// Optional feature: define UP_RAM_WAIT_EN to stall RAM-accessing instructions
// in EXEC until bus.ram_ready is high.
module up_param_core
    import up_param_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PW_W   = DATA_W + 4,
    parameter int unsigned ADDR_W = DATA_W + PW_W
) (
    input  logic              clock,
    input  logic              reset,
    up_param_core_if.master   bus,
    input  logic [DATA_W-1:0] pushbuttons,
    output logic [DATA_W-1:0] FF_out,
    output logic              phase,
    output logic [3:0]        instr,
    output logic [DATA_W-1:0] oprnd,
    output logic [DATA_W-1:0] accu,
    output logic              c_flag,
    output logic              z_flag
);

    phase_e            phase_q, phase_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        instr_q, instr_d;
    logic [DATA_W-1:0] oprnd_q, oprnd_d;
    logic [DATA_W-1:0] accu_q, accu_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] ff_q, ff_d;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              jump_taken;
    logic              stall;
    logic [ADDR_W-1:0] addr;

    // Second program word completes the RAM address / jump target
    assign addr = {oprnd_q, bus.program_byte};

`ifdef UP_RAM_WAIT_EN
    assign stall = (phase_q == PhExec) && is_mem_op(instr_q) && !bus.ram_ready;
`else
    assign stall = 1'b0;
`endif

    // Operand source and ALU operation for the latched opcode
    always_comb begin
        alu_op = AluPass;
        alu_b  = oprnd_q;
        case (instr_q)
            OP_CMPI:  alu_op = AluCmp;
            OP_CMPM:  begin alu_op = AluCmp;  alu_b = bus.ram_rdata; end
            OP_IN:    alu_b = pushbuttons;
            OP_LD:    alu_b = bus.ram_rdata;
            OP_ADDI:  alu_op = AluAdd;
            OP_ADDM:  begin alu_op = AluAdd;  alu_b = bus.ram_rdata; end
            OP_NANDI: alu_op = AluNand;
            OP_NANDM: begin alu_op = AluNand; alu_b = bus.ram_rdata; end
            default:  ;
        endcase
    end

    up_param_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (accu_q),
        .b_i      (alu_b),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    // Branch condition from the current flags
    always_comb begin
        jump_taken = 1'b0;
        case (instr_q)
            OP_JC:   jump_taken = c_q;
            OP_JNC:  jump_taken = !c_q;
            OP_JZ:   jump_taken = z_q;
            OP_JNZ:  jump_taken = !z_q;
            OP_JMP:  jump_taken = 1'b1;
            default: jump_taken = 1'b0;
        endcase
    end

    // Fetch/exec sequencer and next-state of all architectural registers
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        accu_d  = accu_q;
        c_d     = c_q;
        z_d     = z_q;
        ff_d    = ff_q;
        unique case (phase_q)
            PhFetch: begin
                {instr_d, oprnd_d} = bus.program_byte;
                pc_d               = pc_q + ADDR_W'(1);
                phase_d            = PhExec;
            end
            PhExec: begin
                if (!stall) begin
                    phase_d = PhFetch;
                    if (is_two_word(instr_q)) begin
                        pc_d = (is_jump(instr_q) && jump_taken) ? addr : pc_q + ADDR_W'(1);
                    end
                    case (instr_q)
                        OP_CMPI, OP_CMPM: begin
                            c_d = alu_carry;
                            z_d = alu_zero;
                        end
                        OP_LIT, OP_IN, OP_LD, OP_NANDI, OP_NANDM: begin
                            accu_d = alu_result;
                            z_d    = alu_zero;
                        end
                        OP_ADDI, OP_ADDM: begin
                            accu_d = alu_result;
                            c_d    = alu_carry;
                            z_d    = alu_zero;
                        end
                        OP_OUT:  ff_d = accu_q;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Architectural state; asynchronous reset aborts any instruction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= PhFetch;
            pc_q    <= '0;
            instr_q <= '0;
            oprnd_q <= '0;
            accu_q  <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ff_q    <= '0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            accu_q  <= accu_d;
            c_q     <= c_d;
            z_q     <= z_d;
            ff_q    <= ff_d;
        end
    end

    // Write strobe stays high through wait states; gated by reset so it drops immediately
    assign bus.ram_we      = reset && (phase_q == PhExec) && (instr_q == OP_ST);
    assign bus.data_bus    = (instr_q == OP_ST) ? accu_q :
                             (is_mem_op(instr_q) ? bus.ram_rdata : oprnd_q);
    assign bus.PC          = pc_q;
    assign bus.address_RAM = addr;

    assign phase  = phase_q;
    assign instr  = instr_q;
    assign oprnd  = oprnd_q;
    assign accu   = accu_q;
    assign c_flag = c_q;
    assign z_flag = z_q;
    assign FF_out = ff_q;

endmodule

// File: tb/tb_up_param_core.sv
// Directed bench for up_param_core: ROM/RAM models, a fixed program walking
// through every opcode class, PC wrap, and an asynchronous reset during an ST.
module tb_up_param_core;

    logic       clock;
    logic       reset;
    logic [3:0] pushbuttons;
    logic [3:0] FF_out;
    logic       phase;
    logic [3:0] instr;
    logic [3:0] oprnd;
    logic [3:0] accu;
    logic       c_flag;
    logic       z_flag;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rom [4096];
    logic [3:0] ram [4096];

    up_param_core_if #(.DATA_W(4), .PW_W(8), .ADDR_W(12)) bus ();

`ifdef UP_RAM_WAIT_EN
    logic ready;
    assign bus.ram_ready = ready;
`endif

    assign bus.program_byte = rom[bus.PC];
    assign bus.ram_rdata    = ram[bus.address_RAM];

    always @(posedge clock) begin
        if (bus.ram_we) ram[bus.address_RAM] <= bus.data_bus;
    end

    up_param_core #(
        .DATA_W (4),
        .PW_W   (8),
        .ADDR_W (12)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .pushbuttons (pushbuttons),
        .FF_out      (FF_out),
        .phase       (phase),
        .instr       (instr),
        .oprnd       (oprnd),
        .accu        (accu),
        .c_flag      (c_flag),
        .z_flag      (z_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_acc(input string tag, input logic [3:0] a, input logic c, input logic z);
        check({tag, ".accu"}, 32'(accu), 32'(a));
        check({tag, ".c"}, 32'(c_flag), 32'(c));
        check({tag, ".z"}, 32'(z_flag), 32'(z));
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'h00;
            ram[i] = 4'h0;
        end
        rom[12'h000] = 8'h4F; // LIT F
        rom[12'h001] = 8'hA1; // ADDI 1
        rom[12'h002] = 8'hE0; // NANDI 0
        rom[12'h003] = 8'h45; // LIT 5
        rom[12'h004] = 8'h25; // CMPI 5
        rom[12'h005] = 8'h80; // JZ 0x020
        rom[12'h006] = 8'h20;
        rom[12'h020] = 8'h45; // LIT 5
        rom[12'h021] = 8'h24; // CMPI 4
        rom[12'h022] = 8'h80; // JZ 0x040 (not taken)
        rom[12'h023] = 8'h40;
        rom[12'h024] = 8'h49; // LIT 9
        rom[12'h025] = 8'h71; // ST 0x123
        rom[12'h026] = 8'h23;
        rom[12'h027] = 8'h40; // LIT 0
        rom[12'h028] = 8'h61; // LD 0x123
        rom[12'h029] = 8'h23;
        rom[12'h02A] = 8'h50; // IN
        rom[12'h02B] = 8'hD0; // OUT
        rom[12'h02C] = 8'hCF; // JMP 0xFFE
        rom[12'h02D] = 8'hFE;
        rom[12'hFFE] = 8'h43; // LIT 3
        rom[12'hFFF] = 8'hC0; // JMP {0, rom[0]} = 0x04F
        rom[12'h04F] = 8'h4A; // LIT A
        rom[12'h050] = 8'hF1; // NANDM 0x123
        rom[12'h051] = 8'h23;
        rom[12'h052] = 8'hB1; // ADDM 0x123
        rom[12'h053] = 8'h23;
        rom[12'h054] = 8'h10; // JNC 0x070 (not taken)
        rom[12'h055] = 8'h70;
        rom[12'h056] = 8'h00; // JC 0x060
        rom[12'h057] = 8'h60;
        rom[12'h060] = 8'h31; // CMPM 0x123
        rom[12'h061] = 8'h23;
        rom[12'h062] = 8'h90; // JNZ 0x080
        rom[12'h063] = 8'h80;
        rom[12'h080] = 8'h42; // LIT 2
        rom[12'h081] = 8'h71; // ST 0x1AB (aborted by reset)
        rom[12'h082] = 8'hAB;

        reset       = 1'b0;
        pushbuttons = 4'h6;
`ifdef UP_RAM_WAIT_EN
        ready       = 1'b1;
`endif
        run(2);
        check("rst.pc", 32'(bus.PC), 32'h000);
        check("rst.phase", 32'(phase), 32'h0);
        check("rst.we", 32'(bus.ram_we), 32'h0);
        check_acc("rst", 4'h0, 1'b0, 1'b0);

        reset = 1'b1;
        check("rel.pc", 32'(bus.PC), 32'h000);
        run(1);
        check("fetch0.phase", 32'(phase), 32'h1);
        check("fetch0.instr", 32'(instr), 32'h4);
        check("fetch0.oprnd", 32'(oprnd), 32'hF);
        check("fetch0.pc", 32'(bus.PC), 32'h001);
        run(1);
        check("lit.phase", 32'(phase), 32'h0);
        check_acc("litF", 4'hF, 1'b0, 1'b0);
        run(2);
        check_acc("addi", 4'h0, 1'b1, 1'b1);
        run(2);
        check_acc("nandi", 4'hF, 1'b1, 1'b0);
        run(4);
        check_acc("cmpi5", 4'h5, 1'b1, 1'b1);
        run(1);
        check("jz.fetch.pc", 32'(bus.PC), 32'h006);
        run(1);
        check("jz.taken.pc", 32'(bus.PC), 32'h020);
        run(4);
        check_acc("cmpi4", 4'h5, 1'b1, 1'b0);
        run(2);
        check("jz.fall.pc", 32'(bus.PC), 32'h024);

        run(2);
        run(1);
        check("st.we", 32'(bus.ram_we), 32'h1);
        check("st.addr", 32'(bus.address_RAM), 32'h123);
        check("st.data", 32'(bus.data_bus), 32'h9);
        run(1);
        check("st.we.off", 32'(bus.ram_we), 32'h0);
        check("st.ram", 32'(ram[12'h123]), 32'h9);
        check("st.pc", 32'(bus.PC), 32'h027);
        run(2);
        check_acc("lit0", 4'h0, 1'b1, 1'b1);
`ifdef UP_RAM_WAIT_EN
        ready = 1'b0;
        run(1);
        for (int i = 0; i < 3; i++) begin
            run(1);
            check("wait.phase", 32'(phase), 32'h1);
            check("wait.pc", 32'(bus.PC), 32'h029);
            check("wait.accu", 32'(accu), 32'h0);
        end
        ready = 1'b1;
        run(1);
        check("wait.done.phase", 32'(phase), 32'h0);
`else
        run(2);
`endif
        check_acc("ld", 4'h9, 1'b1, 1'b0);
        check("ld.pc", 32'(bus.PC), 32'h02A);
        run(2);
        check_acc("in", 4'h6, 1'b1, 1'b0);
        run(1);
        check("out.before", 32'(FF_out), 32'h0);
        run(1);
        check("out.after", 32'(FF_out), 32'h6);
        run(2);
        check("jmp.pc", 32'(bus.PC), 32'hFFE);
        run(2);
        check_acc("lit3", 4'h3, 1'b1, 1'b0);
        run(1);
        check("wrap.pc", 32'(bus.PC), 32'h000);
        run(1);
        check("wrap.target", 32'(bus.PC), 32'h04F);

        run(4);
        check_acc("nandm", 4'h7, 1'b1, 1'b0);
        run(2);
        check_acc("addm", 4'h0, 1'b1, 1'b1);
        run(2);
        check("jnc.fall.pc", 32'(bus.PC), 32'h056);
        run(2);
        check("jc.taken.pc", 32'(bus.PC), 32'h060);
        run(2);
        check_acc("cmpm", 4'h0, 1'b0, 1'b0);
        run(2);
        check("jnz.taken.pc", 32'(bus.PC), 32'h080);

        run(2);
        run(1);
        check("st2.we", 32'(bus.ram_we), 32'h1);
        check("st2.addr", 32'(bus.address_RAM), 32'h1AB);
        reset = 1'b0;
        #1;
        check("abort.we", 32'(bus.ram_we), 32'h0);
        check("abort.pc", 32'(bus.PC), 32'h000);
        check("abort.phase", 32'(phase), 32'h0);
        check("abort.instr", 32'(instr), 32'h0);
        check("abort.oprnd", 32'(oprnd), 32'h0);
        check("abort.ff", 32'(FF_out), 32'h0);
        check("abort.data", 32'(bus.data_bus), 32'h0);
        check_acc("abort", 4'h0, 1'b0, 1'b0);
        run(1);
        check("abort.ram", 32'(ram[12'h1AB]), 32'h0);
        check("abort.pc.held", 32'(bus.PC), 32'h000);
        reset = 1'b1;
        check("rel2.pc", 32'(bus.PC), 32'h000);
        run(1);
        check("refetch.instr", 32'(instr), 32'h4);
        check("refetch.oprnd", 32'(oprnd), 32'hF);
        check("refetch.pc", 32'(bus.PC), 32'h001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
